// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the CSR sequencer and its read-modify-write helper.
package csr_ctrl_pkg;

    localparam int CREG_W = 5;

    typedef logic [CREG_W-1:0] creg_addr_t;

    typedef enum logic [2:0] {
        CSR_RW = 3'd0,
        CSR_RS = 3'd1,
        CSR_RC = 3'd2,
        TRAP   = 3'd3,
        MRET   = 3'd4
    } csr_op_t;

    localparam creg_addr_t CSR_MSTATUS  = 5'd0;
    localparam creg_addr_t CSR_MTVEC    = 5'd1;
    localparam creg_addr_t CSR_MEPC     = 5'd2;
    localparam creg_addr_t CSR_MCAUSE   = 5'd3;
    localparam creg_addr_t CSR_MTVAL    = 5'd4;
    localparam creg_addr_t CSR_MIE      = 5'd5;
    localparam creg_addr_t CSR_MIP      = 5'd6;
    localparam creg_addr_t CSR_MSCRATCH = 5'd7;
    localparam creg_addr_t CSR_MHARTID  = 5'd24;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CSR_EXEC    = 3'd1,
        TRAP_EPC    = 3'd2,
        TRAP_CAUSE  = 3'd3,
        TRAP_TVAL   = 3'd4,
        TRAP_STATUS = 3'd5,
        MRET_EXEC   = 3'd6
    } ctrl_state_t;

    function automatic logic is_rmw_op(input logic [2:0] op);
        return (op == CSR_RW) || (op == CSR_RS) || (op == CSR_RC);
    endfunction

endpackage

// File: rtl/csr_ctrl_rmw.sv
// Combinational CSR read-modify-write: computes the new value and decides
// whether the write goes ahead or is rejected as a read-only access.
module csr_rmw
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RO_BASE = 24
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    input  creg_addr_t      addr_i,
    output logic [XLEN-1:0] new_o,
    output logic            wen_o,
    output logic            illegal_o
);

    logic want_write;
    logic read_only;

    always_comb begin
        new_o      = '0;
        want_write = 1'b0;
        case (op_i)
            CSR_RW: begin
                new_o      = src_i;
                want_write = 1'b1;
            end
            CSR_RS: begin
                new_o      = old_i | src_i;
                want_write = (src_i != '0);
            end
            CSR_RC: begin
                new_o      = old_i & ~src_i;
                want_write = (src_i != '0);
            end
            default: begin
                new_o      = '0;
                want_write = 1'b0;
            end
        endcase
    end

    // A set/clear with a zero mask is a pure read, so it never counts as illegal.
    assign read_only = (int'(addr_i) >= RO_BASE);
    assign wen_o     = want_write && !read_only;
    assign illegal_o = want_write && read_only;

endmodule

// File: rtl/csr_ctrl.sv
// CSR/trap sequencer: time-multiplexes the csrfile write port for CSR RMW ops,
// multi-register trap entry and MRET, and returns old data or a redirect.
//
// state       | meaning
// IDLE        | waiting for a request, req_ready high
// CSR_EXEC    | read old value, write RMW result, respond
// TRAP_EPC    | write MEPC with aligned faulting PC
// TRAP_CAUSE  | write MCAUSE
// TRAP_TVAL   | write MTVAL
// TRAP_STATUS | update MSTATUS, respond with MTVEC-derived target
// MRET_EXEC   | restore MSTATUS, respond with MEPC target
module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int RO_BASE = 24,
    parameter int XLEN    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [4:0]      req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_cause,
    input  logic [XLEN-1:0] req_tval,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_target,
    output logic [4:0]      csr_ra1,
    output logic [4:0]      csr_ra2,
    input  logic [XLEN-1:0] csr_rd1,
    input  logic [XLEN-1:0] csr_rd2,
    output logic            csr_wen,
    output logic [4:0]      csr_wa,
    output logic [XLEN-1:0] csr_wd
);

    ctrl_state_t     state_q, state_d;
    logic [2:0]      op_q;
    creg_addr_t      addr_q;
    logic [XLEN-1:0] src_q, pc_q, cause_q, tval_q;

    logic [XLEN-1:0] rmw_new;
    logic            rmw_wen;
    logic            rmw_illegal;
    logic [XLEN-1:0] tvec_base;

    csr_rmw #(
        .XLEN    (XLEN),
        .RO_BASE (RO_BASE)
    ) u_rmw (
        .op_i      (op_q),
        .old_i     (csr_rd1),
        .src_i     (src_q),
        .addr_i    (addr_q),
        .new_o     (rmw_new),
        .wen_o     (rmw_wen),
        .illegal_o (rmw_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            src_q   <= req_src;
            pc_q    <= req_pc;
            cause_q <= req_cause;
            tval_q  <= req_tval;
        end
    end

    assign tvec_base = {csr_rd2[XLEN-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_illegal  = 1'b0;
        resp_redirect = 1'b0;
        resp_target   = '0;
        csr_ra1       = '0;
        csr_ra2       = '0;
        csr_wen       = 1'b0;
        csr_wa        = '0;
        csr_wd        = '0;

        // Reset blanks the outputs in the same cycle so a mid-sequence write is dropped.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        case (req_op)
                            TRAP:    state_d = TRAP_EPC;
                            MRET:    state_d = MRET_EXEC;
                            default: state_d = CSR_EXEC;
                        endcase
                    end
                end
                CSR_EXEC: begin
                    resp_valid = 1'b1;
                    if (is_rmw_op(op_q)) begin
                        csr_ra1      = addr_q;
                        resp_rdata   = csr_rd1;
                        resp_illegal = rmw_illegal;
                        csr_wen      = rmw_wen;
                        csr_wa       = rmw_wen ? addr_q : '0;
                        csr_wd       = rmw_wen ? rmw_new : '0;
                    end
                    state_d = IDLE;
                end
                TRAP_EPC: begin
                    csr_wen = 1'b1;
                    csr_wa  = CSR_MEPC;
                    csr_wd  = {pc_q[XLEN-1:2], 2'b00};
                    state_d = TRAP_CAUSE;
                end
                TRAP_CAUSE: begin
                    csr_wen = 1'b1;
                    csr_wa  = CSR_MCAUSE;
                    csr_wd  = cause_q;
                    state_d = TRAP_TVAL;
                end
                TRAP_TVAL: begin
                    csr_wen = 1'b1;
                    csr_wa  = CSR_MTVAL;
                    csr_wd  = tval_q;
                    state_d = TRAP_STATUS;
                end
                TRAP_STATUS: begin
                    csr_ra1                               = CSR_MSTATUS;
                    csr_ra2                               = CSR_MTVEC;
                    csr_wen                               = 1'b1;
                    csr_wa                                = CSR_MSTATUS;
                    csr_wd                                = csr_rd1;
                    csr_wd[MSTATUS_MPIE]                  = csr_rd1[MSTATUS_MIE];
                    csr_wd[MSTATUS_MIE]                   = 1'b0;
                    csr_wd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    resp_valid                            = 1'b1;
                    resp_redirect                         = 1'b1;
                    // Vectored mode offsets only interrupts, by 4 bytes per cause code.
                    if (csr_rd2[1:0] == 2'b01 && cause_q[XLEN-1]) begin
                        resp_target = tvec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
                    end else begin
                        resp_target = tvec_base;
                    end
                    state_d = IDLE;
                end
                MRET_EXEC: begin
                    csr_ra1                               = CSR_MSTATUS;
                    csr_ra2                               = CSR_MEPC;
                    csr_wen                               = 1'b1;
                    csr_wa                                = CSR_MSTATUS;
                    csr_wd                                = csr_rd1;
                    csr_wd[MSTATUS_MIE]                   = csr_rd1[MSTATUS_MPIE];
                    csr_wd[MSTATUS_MPIE]                  = 1'b1;
                    csr_wd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
                    resp_valid                            = 1'b1;
                    resp_redirect                         = 1'b1;
                    resp_target                           = csr_rd2;
                    state_d                               = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a behavioural two-read/one-write csrfile.
module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_addr;
    logic [63:0] req_src, req_pc, req_cause, req_tval;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_illegal;
    logic        resp_redirect;
    logic [63:0] resp_target;
    logic [4:0]  csr_ra1, csr_ra2;
    logic [63:0] csr_rd1, csr_rd2;
    logic        csr_wen;
    logic [4:0]  csr_wa;
    logic [63:0] csr_wd;

    logic [63:0] mem [0:31];
    logic        mem_init;
    logic        bd_en;
    logic [4:0]  bd_addr;
    logic [63:0] bd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_ctrl #(.RO_BASE(24), .XLEN(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_src       (req_src),
        .req_pc        (req_pc),
        .req_cause     (req_cause),
        .req_tval      (req_tval),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_illegal  (resp_illegal),
        .resp_redirect (resp_redirect),
        .resp_target   (resp_target),
        .csr_ra1       (csr_ra1),
        .csr_ra2       (csr_ra2),
        .csr_rd1       (csr_rd1),
        .csr_rd2       (csr_rd2),
        .csr_wen       (csr_wen),
        .csr_wa        (csr_wa),
        .csr_wd        (csr_wd)
    );

    assign csr_rd1 = mem[csr_ra1];
    assign csr_rd2 = mem[csr_ra2];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (csr_wen) begin
            mem[csr_wa] <= csr_wd;
        end
    end

    // Backdoor preload through the csrfile write process; called only while the DUT is idle.
    task automatic poke(input logic [4:0] a, input logic [63:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); @(negedge clk);
        bd_en = 1'b0;
        #1;
    endtask

    // Presents one request for a single accepting edge; returns at T+1, #1 after the negedge.
    task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [63:0] src,
                         input logic [63:0] pc, input logic [63:0] cause, input logic [63:0] tval);
        req_valid = 1'b1; req_op = op; req_addr = a; req_src = src;
        req_pc = pc; req_cause = cause; req_tval = tval;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_src = '0;
        req_pc = '0; req_cause = '0; req_tval = '0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
        req_pc = '0; req_cause = '0; req_tval = '0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        #1;
        checks++; if (csr_wen !== 1'b0) begin errors++; $display("FAIL rst_wen_in_reset: got %0b want 0", csr_wen); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset: got %0b want 0", req_ready); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 64'h0 || resp_target !== 64'h0) begin
            errors++; $display("FAIL rst_resp: got v=%0b rd=%0h tg=%0h want all 0", resp_valid, resp_rdata, resp_target); end
    endtask

    task automatic test_rw_then_rs();
        issue(3'd0, 5'd7, 64'hDEAD_BEEF, 0, 0, 0);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rw_valid: got %0b want 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL rw_rdata: got %0h want 0", resp_rdata); end
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd7 || csr_wd !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL rw_write: got wen=%0b wa=%0d wd=%0h want 1 7 deadbeef", csr_wen, csr_wa, csr_wd); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rw_ready_busy: got %0b want 0", req_ready); end
        next_cycle();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rw_back_idle: got rdy=%0b v=%0b want 1 0", req_ready, resp_valid); end
        // back-to-back: accept in the cycle right after the response
        issue(3'd1, 5'd7, 64'h0, 0, 0, 0);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL rs0_rdata: got v=%0b rd=%0h want 1 deadbeef", resp_valid, resp_rdata); end
        checks++; if (csr_wen !== 1'b0 || resp_illegal !== 1'b0) begin
            errors++; $display("FAIL rs0_nowrite: got wen=%0b ill=%0b want 0 0", csr_wen, resp_illegal); end
        next_cycle();
    endtask

    task automatic test_rc_and_readonly();
        poke(5'd0, 64'h88);
        issue(3'd2, 5'd0, 64'h8, 0, 0, 0);
        checks++; if (resp_rdata !== 64'h88) begin errors++; $display("FAIL rc_rdata: got %0h want 88", resp_rdata); end
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd0 || csr_wd !== 64'h80) begin
            errors++; $display("FAIL rc_write: got wen=%0b wa=%0d wd=%0h want 1 0 80", csr_wen, csr_wa, csr_wd); end
        next_cycle();
        poke(5'd24, 64'h42);
        issue(3'd0, 5'd24, 64'h5, 0, 0, 0);
        checks++; if (resp_illegal !== 1'b1 || csr_wen !== 1'b0) begin
            errors++; $display("FAIL ro_illegal: got ill=%0b wen=%0b want 1 0", resp_illegal, csr_wen); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h42) begin
            errors++; $display("FAIL ro_rdata: got v=%0b rd=%0h want 1 42", resp_valid, resp_rdata); end
        next_cycle();
        // zero-mask set on a read-only index is a plain read, not illegal
        issue(3'd1, 5'd24, 64'h0, 0, 0, 0);
        checks++; if (resp_illegal !== 1'b0 || csr_wen !== 1'b0 || resp_rdata !== 64'h42) begin
            errors++; $display("FAIL ro_rs0: got ill=%0b wen=%0b rd=%0h want 0 0 42", resp_illegal, csr_wen, resp_rdata); end
        next_cycle();
    endtask

    task automatic test_trap();
        poke(5'd1, 64'h8000_1000);
        poke(5'd0, 64'h8);
        issue(3'd3, 5'd0, 0, 64'h8000_0106, 64'h2, 64'h13);
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd2 || csr_wd !== 64'h8000_0104 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL trap_t1: got wen=%0b wa=%0d wd=%0h rdy=%0b v=%0b want 1 2 80000104 0 0", csr_wen, csr_wa, csr_wd, req_ready, resp_valid); end
        next_cycle();
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd3 || csr_wd !== 64'h2 || req_ready !== 1'b0) begin
            errors++; $display("FAIL trap_t2: got wen=%0b wa=%0d wd=%0h rdy=%0b want 1 3 2 0", csr_wen, csr_wa, csr_wd, req_ready); end
        next_cycle();
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd4 || csr_wd !== 64'h13 || req_ready !== 1'b0) begin
            errors++; $display("FAIL trap_t3: got wen=%0b wa=%0d wd=%0h rdy=%0b want 1 4 13 0", csr_wen, csr_wa, csr_wd, req_ready); end
        next_cycle();
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd0 || csr_wd !== 64'h1880 || req_ready !== 1'b0) begin
            errors++; $display("FAIL trap_t4_status: got wen=%0b wa=%0d wd=%0h rdy=%0b want 1 0 1880 0", csr_wen, csr_wa, csr_wd, req_ready); end
        checks++; if (resp_valid !== 1'b1 || resp_redirect !== 1'b1 || resp_target !== 64'h8000_1000) begin
            errors++; $display("FAIL trap_t4_resp: got v=%0b rr=%0b tg=%0h want 1 1 80001000", resp_valid, resp_redirect, resp_target); end
        next_cycle();
        checks++; if (mem[2] !== 64'h8000_0104 || mem[3] !== 64'h2 || mem[4] !== 64'h13 || mem[0] !== 64'h1880) begin
            errors++; $display("FAIL trap_csrs: got epc=%0h cause=%0h tval=%0h st=%0h want 80000104 2 13 1880", mem[2], mem[3], mem[4], mem[0]); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL trap_idle: got rdy=%0b v=%0b want 1 0", req_ready, resp_valid); end
    endtask

    task automatic test_trap_vectored();
        poke(5'd1, 64'h8000_1001);
        issue(3'd3, 5'd0, 0, 64'h8000_0300, 64'h8000_0000_0000_0007, 64'h0);
        repeat (3) next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_target !== 64'h8000_101C) begin
            errors++; $display("FAIL trap_vec_target: got v=%0b tg=%0h want 1 8000101c", resp_valid, resp_target); end
        next_cycle();
        // vectored MTVEC but synchronous cause: no offset
        issue(3'd3, 5'd0, 0, 64'h8000_0300, 64'h7, 64'h0);
        repeat (3) next_cycle();
        checks++; if (resp_target !== 64'h8000_1000) begin
            errors++; $display("FAIL trap_vec_sync: got tg=%0h want 80001000", resp_target); end
        next_cycle();
    endtask

    task automatic test_mret();
        poke(5'd0, 64'h1880);
        poke(5'd2, 64'h8000_0200);
        issue(3'd4, 5'd0, 0, 0, 0, 0);
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd0 || csr_wd !== 64'h88) begin
            errors++; $display("FAIL mret_write: got wen=%0b wa=%0d wd=%0h want 1 0 88", csr_wen, csr_wa, csr_wd); end
        checks++; if (resp_valid !== 1'b1 || resp_redirect !== 1'b1 || resp_target !== 64'h8000_0200 || resp_rdata !== 64'h0) begin
            errors++; $display("FAIL mret_resp: got v=%0b rr=%0b tg=%0h rd=%0h want 1 1 80000200 0", resp_valid, resp_redirect, resp_target, resp_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid_trap();
        poke(5'd2, 64'h0);
        poke(5'd3, 64'h55);
        poke(5'd4, 64'h77);
        issue(3'd3, 5'd0, 0, 64'h102, 64'h9, 64'h7);
        checks++; if (csr_wen !== 1'b1 || csr_wa !== 5'd2) begin
            errors++; $display("FAIL midrst_t1: got wen=%0b wa=%0d want 1 2", csr_wen, csr_wa); end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (csr_wen !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_t2: got wen=%0b v=%0b want 0 0", csr_wen, resp_valid); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (csr_wen !== 1'b0 || resp_valid !== 1'b0 || resp_redirect !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_after: got wen=%0b v=%0b rr=%0b rdy=%0b want 0 0 0 1", csr_wen, resp_valid, resp_redirect, req_ready); end
        next_cycle();
        checks++; if (mem[2] !== 64'h100 || mem[3] !== 64'h55 || mem[4] !== 64'h77) begin
            errors++; $display("FAIL midrst_csrs: got epc=%0h cause=%0h tval=%0h want 100 55 77", mem[2], mem[3], mem[4]); end
    endtask

    task automatic test_undef_op();
        poke(5'd0, 64'hFFFF);
        issue(3'd6, 5'd0, 64'h1, 64'h1234, 64'h1, 64'h1);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL undef_valid: got %0b want 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h0 || resp_illegal !== 1'b0 || resp_redirect !== 1'b0 || resp_target !== 64'h0 || csr_wen !== 1'b0) begin
            errors++; $display("FAIL undef_fields: got rd=%0h ill=%0b rr=%0b tg=%0h wen=%0b want all 0", resp_rdata, resp_illegal, resp_redirect, resp_target, csr_wen); end
        next_cycle();
        checks++; if (req_ready !== 1'b1 || mem[0] !== 64'hFFFF) begin
            errors++; $display("FAIL undef_idle: got rdy=%0b st=%0h want 1 ffff", req_ready, mem[0]); end
    endtask

    initial begin
        test_reset();
        test_rw_then_rs();
        test_rc_and_readonly();
        test_trap();
        test_trap_vectored();
        test_mret();
        test_reset_mid_trap();
        test_undef_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
